// File: rtl/stats_pkg.sv
// Shared constants, FSM state type and byte-index type for the statistics report framer.
package stats_pkg;
    localparam logic [7:0] HEADER    = 8'hA5;
    localparam int         FRAME_LEN = 8;
    localparam int         IDX_W     = $clog2(FRAME_LEN);
    localparam int         SNAP_W    = 16;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/stats_byte_sel.sv
// Combinational frame byte selector: maps a captured snapshot and byte index to the frame byte.
module stats_byte_sel
    import stats_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = stats_pkg::HEADER
) (
    input  logic [SNAP_W-1:0] cp,
    input  logic [SNAP_W-1:0] tb,
    input  idx_t              idx,
    output logic [7:0]        frame_byte
);

    logic [SNAP_W-1:0] miss;
    logic [7:0]        csum;

    // Miss count wraps modulo 2^16 when CP exceeds TB; the checksum is a plain byte sum.
    always_comb begin
        miss = tb - cp;
        csum = HEADER_BYTE + cp[15:8] + cp[7:0] + tb[15:8] + tb[7:0]
             + miss[15:8] + miss[7:0];
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            3'd0:    frame_byte = HEADER_BYTE;
            3'd1:    frame_byte = cp[15:8];
            3'd2:    frame_byte = cp[7:0];
            3'd3:    frame_byte = tb[15:8];
            3'd4:    frame_byte = tb[7:0];
            3'd5:    frame_byte = miss[15:8];
            3'd6:    frame_byte = miss[7:0];
            3'd7:    frame_byte = csum;
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/stats_reporter.sv
// Sends an 8-byte valid/ready frame carrying a snapshot of the branch-prediction counters on request.
module stats_reporter #(
    parameter int         TRAINING_DATA_SIZE     = 65536,
    parameter int         INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
    parameter logic [7:0] HEADER                 = stats_pkg::HEADER
) (
    input  logic                              Clk,
    input  logic                              reset,
    input  logic [INSTRUCTION_INDEX_SIZE-1:0] CorrectlyPredicted,
    input  logic [INSTRUCTION_INDEX_SIZE-1:0] TotalBranches,
    input  logic                              report_req,
    output logic [7:0]                        tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              busy,
    output logic                              done
);
    import stats_pkg::*;

    if (INSTRUCTION_INDEX_SIZE > SNAP_W) begin : g_width_check
        $error("INSTRUCTION_INDEX_SIZE must not exceed 16");
    end

    state_t            state;
    state_t            state_next;
    idx_t              idx;
    logic [SNAP_W-1:0] snap_cp;
    logic [SNAP_W-1:0] snap_tb;
    logic [7:0]        sel_byte;

    stats_byte_sel #(
        .HEADER_BYTE (HEADER)
    ) u_byte_sel (
        .cp         (snap_cp),
        .tb         (snap_tb),
        .idx        (idx),
        .frame_byte (sel_byte)
    );

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (report_req) state_next = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready && idx == idx_t'(FRAME_LEN - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Snapshot and index only move on transfers, so the byte holds across stalls.
        tx_data = tx_valid ? sel_byte : 8'h00;
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            snap_cp <= '0;
            snap_tb <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && report_req) begin
                snap_cp <= SNAP_W'(CorrectlyPredicted);
                snap_tb <= SNAP_W'(TotalBranches);
                idx     <= '0;
            end else if (state == SEND && tx_ready) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
